spi_flash_reader: RTL and testbench

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_reader.sv | 258 +++++++++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
//  Module   : spi_flash_reader
//  Purpose  : SPI (mode 0) master that reads a block of bytes from a serial
//             NOR flash, using READ (0x03), FAST_READ (0x0B + dummy byte) or
//             JEDEC ID (0x9F), and streams the bytes out through a
//             valid/ready register with back-pressure.
//  Ports    : clk, rst_n            - system clock / async active-low reset
//             start, mode, addr, len- transaction request (captured in IDLE)
//             rd_data, rd_valid,
//             rd_ready              - received byte stream
//             busy, done            - transaction status
//             spi_cs, spi_clk,
//             spi_mosi, spi_miso    - flash interface
//  Revision : 1.0 - initial release
// ============================================================================
module spi_flash_reader #(
    parameter int CLK_DIV   = 2,
    parameter int LEN_W     = 16,
    parameter int FAST_READ = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             busy,
    output logic             done,
    output logic             spi_cs,
    output logic             spi_clk,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0] C_DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] C_GAP_MAX = GAP_W'(2 * CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CS_SETUP, S_CMD, S_ADDR, S_DUMMY,
        S_DATA, S_STALL, S_CS_HOLD, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               sclk_q, sclk_d;
    logic               cs_q, cs_d;
    logic               mosi_q, mosi_d;
    logic [30:0]        tx_q, tx_d;      // bits still to send after mosi_q
    logic [7:0]         rx_q, rx_d;
    logic [2:0]         bit_q, bit_d;    // rising edges seen in current byte
    logic [1:0]         idx_q, idx_d;    // address byte index
    logic [LEN_W-1:0]   cnt_q, cnt_d;    // bytes still to receive
    logic               mode_q, mode_d;
    logic               pend_q, pend_d;  // rx_q holds a complete, unloaded byte
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;

    logic               w_shift, w_tick, w_rise, w_fall, w_load, w_byte_end;
    logic [7:0]         w_cmd;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        sclk_d     = sclk_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_d      = bit_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        pend_d     = pend_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;

        w_cmd      = mode ? 8'h9F : ((FAST_READ != 0) ? 8'h0B : 8'h03);
        w_shift    = (state_q == S_CMD) || (state_q == S_ADDR) ||
                     (state_q == S_DUMMY) || (state_q == S_DATA);
        w_tick     = (div_q == '0);
        w_rise     = w_shift && w_tick && !sclk_q;
        w_fall     = w_shift && w_tick && sclk_q;
        // A fall with bit_q wrapped to 0 closes a byte (8 rises already seen).
        w_byte_end = w_fall && (bit_q == 3'd0);
        w_load     = pend_q && (!rd_valid_q || rd_ready);

        // Minimum CS-high time: counter restarts whenever CS is low.
        gap_d = cs_q ? ((gap_q != '0) ? gap_q - 1'b1 : '0) : C_GAP_MAX;

        // Output register: a new byte may replace one accepted this cycle.
        if (w_load) begin
            rd_data_d  = rx_q;
            rd_valid_d = 1'b1;
            pend_d     = 1'b0;
        end else if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end

        if (w_shift) begin
            div_d = w_tick ? C_DIV_MAX : div_q - 1'b1;
        end
        if (w_rise) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], spi_miso};
            bit_d  = bit_q + 3'd1;
            if (state_q == S_DATA && bit_q == 3'd7) begin
                pend_d = 1'b1;
                cnt_d  = cnt_q - 1'b1;
            end
        end
        if (w_fall) begin
            sclk_d = 1'b0;
            mosi_d = tx_q[30];
            tx_d   = {tx_q[29:0], 1'b0};
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    cnt_d  = len;
                    bit_d  = 3'd0;
                    idx_d  = 2'd0;
                    if (len == '0) begin
                        // Empty request: CS stays high, finish via CS_HOLD.
                        state_d = S_CS_HOLD;
                        div_d   = '0;
                    end else begin
                        state_d = S_CS_SETUP;
                        div_d   = C_DIV_MAX;
                        mosi_d  = w_cmd[7];
                        tx_d    = {w_cmd[6:0], (mode ? 24'h0 : addr)};
                        if (gap_q == '0) begin
                            cs_d = 1'b0;
                        end
                    end
                end
            end
            S_CS_SETUP: begin
                if (cs_q) begin
                    if (gap_q == '0) begin
                        cs_d = 1'b0;
                    end
                end else if (div_q == '0) begin
                    state_d = S_CMD;
                    div_d   = '0;   // first rising edge right away
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            S_CMD: begin
                if (w_byte_end) begin
                    state_d = mode_q ? S_DATA : S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_byte_end) begin
                    if (idx_q == 2'd2) begin
                        state_d = (FAST_READ != 0) ? S_DUMMY : S_DATA;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_DUMMY: begin
                if (w_byte_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_byte_end) begin
                    if (cnt_q == '0) begin
                        state_d = S_CS_HOLD;
                        div_d   = C_DIV_MAX;
                    end else if (pend_q && !w_load) begin
                        state_d = S_STALL;
                    end
                end
            end
            S_STALL: begin
                if (w_load) begin
                    state_d = S_DATA;
                    div_d   = C_DIV_MAX;
                end
            end
            S_CS_HOLD: begin
                if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else begin
                    cs_d = 1'b1;
                    // done only once the last byte has left the output register
                    if (!pend_q && (!rd_valid_q || rd_ready)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            gap_q      <= '0;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            pend_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            gap_q      <= gap_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_q      <= bit_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign spi_cs   = cs_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_flash_reader
//  Purpose  : Self-checking bench for spi_flash_reader. A behavioural flash
//             model answers on MISO; expected command/address bits, edge
//             counts and byte streams are derived from the transaction
//             parameters. Two instances: FAST_READ=0 and FAST_READ=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, mode, rd_ready;
    logic        spi_miso = 1'b0;
    logic [23:0] addr;
    logic [15:0] len;
    logic        sel;

    logic [7:0]  d0_data, d1_data;
    logic        d0_valid, d1_valid, d0_busy, d1_busy, d0_done, d1_done;
    logic        d0_cs, d1_cs, d0_sclk, d1_sclk, d0_mosi, d1_mosi;

    spi_flash_reader #(.CLK_DIV(2), .LEN_W(16), .FAST_READ(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .addr(addr),
        .len(len), .rd_data(d0_data), .rd_valid(d0_valid), .rd_ready(rd_ready),
        .busy(d0_busy), .done(d0_done), .spi_cs(d0_cs), .spi_clk(d0_sclk),
        .spi_mosi(d0_mosi), .spi_miso(spi_miso));

    spi_flash_reader #(.CLK_DIV(2), .LEN_W(16), .FAST_READ(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .addr(addr),
        .len(len), .rd_data(d1_data), .rd_valid(d1_valid), .rd_ready(rd_ready),
        .busy(d1_busy), .done(d1_done), .spi_cs(d1_cs), .spi_clk(d1_sclk),
        .spi_mosi(d1_mosi), .spi_miso(spi_miso));

    wire [7:0] m_data  = sel ? d1_data  : d0_data;
    wire       m_valid = sel ? d1_valid : d0_valid;
    wire       m_busy  = sel ? d1_busy  : d0_busy;
    wire       m_done  = sel ? d1_done  : d0_done;
    wire       m_cs    = sel ? d1_cs    : d0_cs;
    wire       m_sclk  = sel ? d1_sclk  : d0_sclk;
    wire       m_mosi  = sel ? d1_mosi  : d0_mosi;

    int checks = 0, errors = 0;
    int rises = 0, txn_base = 0, hdr_bits = 0, ncyc = 0, done_cnt = 0;
    int hi_run = 0, min_gap = 1000, rdy_pol = 0;
    int byte1_rise_cyc = -1, first_valid_cyc = -1;
    int bp_left = 0, bp_bad = 0, bp_clk_bad = 0, bp_rises = 0, bp_rises_end = 0;
    logic bp_started = 1'b0, prev_sclk = 1'b0, prev_cs = 1'b1, had_low = 1'b0;
    logic cs_low_seen = 1'b0;
    logic [7:0] bp_byte = 8'h00;
    bit        mosi_bits[$];
    logic [7:0] resp[$], got[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: flash model, consumer and monitors, all at the falling clk edge.
    task automatic step();
        int k;
        logic [7:0] b;
        @(negedge clk);
        ncyc++;
        if (!rst_n) had_low = 1'b0;
        if (m_sclk && !prev_sclk && !m_cs) begin
            rises++;
            mosi_bits.push_back(m_mosi);
            if (rises - txn_base == hdr_bits + 8) byte1_rise_cyc = ncyc;
        end
        if (!m_sclk && prev_sclk && !m_cs) begin
            k = rises - txn_base - hdr_bits;
            if (k >= 0 && k < resp.size() * 8) begin
                b = resp[k / 8];
                spi_miso = b[7 - (k % 8)];
            end else begin
                spi_miso = 1'($urandom % 2);
            end
        end
        if (!m_cs) cs_low_seen = 1'b1;
        if (m_cs) hi_run++;
        else begin
            if (prev_cs && had_low && hi_run < min_gap) min_gap = hi_run;
            if (rst_n) had_low = 1'b1;
            hi_run = 0;
        end
        if (m_done) done_cnt++;
        case (rdy_pol)
            0: rd_ready = 1'b1;
            1: rd_ready = ($urandom % 3) != 0;
            default: begin
                if (!bp_started && m_valid) begin
                    bp_started = 1'b1;
                    bp_left    = 50;
                end
                if (bp_started && bp_left > 0) begin
                    rd_ready = 1'b0;
                    if (m_data !== bp_byte) bp_bad++;
                    if (bp_left <= 10 && m_sclk) bp_clk_bad++;
                    if (bp_left == 10) bp_rises = rises;
                    if (bp_left == 1) bp_rises_end = rises;
                    bp_left--;
                end else begin
                    rd_ready = bp_started;
                end
            end
        endcase
        if (m_valid && rd_ready) got.push_back(m_data);
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = ncyc;
        prev_sclk = m_sclk;
        prev_cs   = m_cs;
    endtask

    // Reference: header length and content from the command rules.
    function automatic int hdr_len(input logic md, input logic fast);
        return 8 + (md ? 0 : 24) + ((fast && !md) ? 8 : 0);
    endfunction

    task automatic begin_txn(input logic md, input logic [23:0] a, input logic [15:0] n);
        txn_base = rises;
        hdr_bits = hdr_len(md, sel);
        got.delete();
        mosi_bits.delete();
        byte1_rise_cyc  = -1;
        first_valid_cyc = -1;
        bp_started = 1'b0;
        bp_byte    = (resp.size() > 0) ? resp[0] : 8'h00;
        mode = md; addr = a; len = n; start = 1'b1;
    endtask

    task automatic run_txn(input string tag, input logic md, input logic [23:0] a,
                           input logic [15:0] n, input int pol, input int tail);
        int cyc, done0, ones;
        logic [63:0] gh, eh;
        logic [7:0] cmd;
        done0   = done_cnt;
        rdy_pol = pol;
        begin_txn(md, a, n);
        cyc = 0;
        do begin step(); cyc++; end while (!m_busy && cyc < 40);
        start = 1'b0;
        chk({tag, " busy"}, m_busy, 1'b1);
        cyc = 0;
        while (!m_done && cyc < 5000) begin step(); cyc++; end
        chk({tag, " done_seen"}, m_done, 1'b1);
        chk({tag, " valid_at_done"}, m_valid, 1'b0);
        for (int i = 0; i < tail; i++) step();
        chk({tag, " done_count"}, done_cnt - done0, 1);
        chk({tag, " rises"}, rises - txn_base, hdr_bits + 8 * n);
        chk({tag, " byte_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), got[i], resp[i]);
        chk({tag, " load_latency"}, first_valid_cyc - byte1_rise_cyc, 1);
        cmd = md ? 8'h9F : (sel ? 8'h0B : 8'h03);
        eh  = 64'(cmd);
        if (!md) eh = (eh << 24) | 64'(a);
        if (sel && !md) eh = eh << 8;
        gh = '0;
        for (int i = 0; i < hdr_bits && i < mosi_bits.size(); i++)
            gh = {gh[62:0], 1'(mosi_bits[i])};
        chk({tag, " mosi_header"}, gh, eh);
        ones = 0;
        for (int i = hdr_bits; i < mosi_bits.size(); i++) ones += int'(mosi_bits[i]);
        chk({tag, " mosi_data_zero"}, ones, 0);
    endtask

    task automatic rand_resp(input int n);
        resp.delete();
        for (int i = 0; i < n; i++) resp.push_back(8'($urandom));
    endtask

    initial begin
        int cyc;
        logic [15:0] n;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; addr = '0; len = '0;
        rd_ready = 1'b1; sel = 1'b0;
        repeat (3) step();
        chk("rst spi_cs", m_cs, 1'b1);
        chk("rst spi_clk", m_sclk, 1'b0);
        chk("rst spi_mosi", m_mosi, 1'b0);
        chk("rst rd_valid", m_valid, 1'b0);
        chk("rst rd_data", m_data, 8'h00);
        chk("rst busy", m_busy, 1'b0);
        chk("rst done", m_done, 1'b0);
        rst_n = 1'b1;
        repeat (2) step();

        resp = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
        run_txn("basic", 1'b0, 24'h123456, 16'd4, 0, 5);

        run_txn("backpressure", 1'b0, 24'h123456, 16'd4, 2, 5);
        chk("bp rd_data_stable", bp_bad, 0);
        chk("bp spi_clk_low", bp_clk_bad, 0);
        chk("bp no_rises", bp_rises_end - bp_rises, 0);

        resp = '{8'hEF, 8'h40, 8'h18};
        run_txn("jedec", 1'b1, 24'($urandom), 16'd3, 0, 5);

        // len == 0: CS untouched, done exactly two cycles after start
        cs_low_seen = 1'b0;
        begin_txn(1'b0, 24'h000100, 16'd0);
        step();
        start = 1'b0;
        chk("len0 busy_c1", m_busy, 1'b1);
        chk("len0 done_c1", m_done, 1'b0);
        step();
        chk("len0 done_c2", m_done, 1'b1);
        repeat (4) step();
        chk("len0 cs_never_low", cs_low_seen, 1'b0);

        // back-to-back: second start issued in the done cycle
        min_gap = 1000;
        rand_resp(2);
        run_txn("b2b_a", 1'b0, 24'hFFFFFE, 16'd2, 0, 0);
        run_txn("b2b_b", 1'b0, 24'h000010, 16'd2, 0, 5);
        chk("cs_gap_min_ok", 64'(min_gap >= 4), 64'd1);

        for (int t = 0; t < 4; t++) begin
            n = 16'(1 + $urandom % 5);
            rand_resp(int'(n));
            run_txn($sformatf("rand%0d", t), 1'($urandom % 2), 24'($urandom), n, 1, 3);
        end

        // reset in the middle of the address phase
        rand_resp(3);
        rdy_pol = 0;
        begin_txn(1'b0, 24'hABCDEF, 16'd3);
        cyc = 0;
        do begin step(); cyc++; end while (!m_busy && cyc < 40);
        start = 1'b0;
        cyc = 0;
        while ((rises - txn_base) < 12 && cyc < 500) begin step(); cyc++; end
        chk("midrst reached_addr", 64'((rises - txn_base) >= 12), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst spi_cs", m_cs, 1'b1);
        chk("midrst rd_valid", m_valid, 1'b0);
        chk("midrst spi_clk", m_sclk, 1'b0);
        chk("midrst busy", m_busy, 1'b0);
        chk("midrst rd_data", m_data, 8'h00);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        rand_resp(3);
        run_txn("after_rst", 1'b0, 24'h445566, 16'd3, 1, 5);

        // FAST_READ instance
        rst_n = 1'b0;
        sel   = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        rand_resp(1);
        run_txn("fast", 1'b0, 24'($urandom), 16'd1, 0, 5);
        rand_resp(2);
        run_txn("fast_jedec", 1'b1, 24'($urandom), 16'd2, 0, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
